mac_result_drain: RTL and testbench



---
 rtl/mac_result_drain_if.sv | 29 ++
 rtl/mac_result_drain.sv | 124 ++++++++++++
 tb/tb_mac_result_drain.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_result_drain_if.sv
// Snapshot/stream bundle between the MAC array, the drain block and the output path.
// The slave modport is the drain block; the master modport is its environment.
interface mac_result_drain_if #(
  parameter int NUM_MACS     = 4,
  parameter int IN_WIDTH     = 32,
  parameter int OUTPUT_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_MACS);

  logic                         capture_valid;
  logic                         capture_ready;
  logic [NUM_MACS*IN_WIDTH-1:0] mac_values;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUTPUT_WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]             out_index;
  logic                         out_last;
  logic                         busy;

  modport slave (
    input  capture_valid, mac_values, out_ready,
    output capture_ready, out_valid, out_data, out_index, out_last, busy
  );

  modport master (
    output capture_valid, mac_values, out_ready,
    input  capture_ready, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/mac_result_drain.sv
// Captures NUM_MACS accumulator results in one cycle, requantizes them (shift, ReLU, saturate)
// and streams them out one per valid/ready beat, with no bubble between back-to-back snapshots.
module mac_result_drain #(
  parameter int NUM_MACS     = 4,
  parameter int IN_WIDTH     = 32,
  parameter int OUTPUT_WIDTH = 8,
  parameter int OUTPUT_SCALE = 0,
  parameter int RELU_EN      = 1
) (
  input  logic              clk,
  input  logic              rst_in,
  mac_result_drain_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MACS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
    {{(IN_WIDTH-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
    {{(IN_WIDTH-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [OUTPUT_WIDTH-1:0] buf_q [NUM_MACS];
  logic [OUTPUT_WIDTH-1:0] buf_d [NUM_MACS];
  logic                    last_s, cap_ready_s, cap_fire_s, beat_fire_s;

  // Comparisons stay at full IN_WIDTH so large accumulators saturate instead of wrapping.
  function automatic logic [OUTPUT_WIDTH-1:0] requant(input logic signed [IN_WIDTH-1:0] v);
    logic signed [IN_WIDTH-1:0] s;
    s = v >>> OUTPUT_SCALE;
    if ((RELU_EN != 0) && s[IN_WIDTH-1]) begin
      s = '0;
    end else begin
      s = s;
    end
    if (s > SAT_MAX) begin
      requant = SAT_MAX[OUTPUT_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      requant = SAT_MIN[OUTPUT_WIDTH-1:0];
    end else begin
      requant = s[OUTPUT_WIDTH-1:0];
    end
  endfunction

  assign last_s      = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
  assign cap_ready_s = (state_q == ST_IDLE) || (last_s && bus.out_ready);
  assign cap_fire_s  = bus.capture_valid && cap_ready_s;
  assign beat_fire_s = (state_q == ST_DRAIN) && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, index and snapshot buffer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_fire_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (beat_fire_s && last_s && !cap_fire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cap_fire_s) begin
      idx_d = '0;
      for (int i = 0; i < NUM_MACS; i++) begin
        buf_d[i] = requant($signed(bus.mac_values[i*IN_WIDTH +: IN_WIDTH]));
      end
    end else if (beat_fire_s) begin
      if (last_s) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Datapath registers; reset clears the buffer so idle output reads zero
  always_ff @(posedge clk) begin
    if (rst_in) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_MACS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  // Outputs decoded from state; out_data is a mux of registered buffer entries
  always_comb begin
    bus.out_valid     = (state_q == ST_DRAIN);
    bus.busy          = (state_q == ST_DRAIN);
    bus.out_data      = buf_q[idx_q];
    bus.out_index     = idx_q;
    bus.out_last      = last_s;
    bus.capture_ready = cap_ready_s;
  end
endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench: three drain instances with different requantization settings share
// stimulus; expected beats are queued at capture time and checked whenever outputs are sampled.
module tb_mac_result_drain;
  localparam int N  = 4;
  localparam int IW = 32;
  localparam int OW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in;
  logic          cap_valid;
  logic          out_rdy;
  logic [N*IW-1:0] mac_vals;

  mac_result_drain_if #(.NUM_MACS(N), .IN_WIDTH(IW), .OUTPUT_WIDTH(OW)) if0 ();
  mac_result_drain_if #(.NUM_MACS(N), .IN_WIDTH(IW), .OUTPUT_WIDTH(OW)) if1 ();
  mac_result_drain_if #(.NUM_MACS(N), .IN_WIDTH(IW), .OUTPUT_WIDTH(OW)) if2 ();

  assign if0.capture_valid = cap_valid;
  assign if0.mac_values    = mac_vals;
  assign if0.out_ready     = out_rdy;
  assign if1.capture_valid = cap_valid;
  assign if1.mac_values    = mac_vals;
  assign if1.out_ready     = out_rdy;
  assign if2.capture_valid = cap_valid;
  assign if2.mac_values    = mac_vals;
  assign if2.out_ready     = out_rdy;

  mac_result_drain #(.NUM_MACS(N), .IN_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(0), .RELU_EN(0))
    u0 (.clk(clk), .rst_in(rst_in), .bus(if0));
  mac_result_drain #(.NUM_MACS(N), .IN_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(2), .RELU_EN(1))
    u1 (.clk(clk), .rst_in(rst_in), .bus(if1));
  mac_result_drain #(.NUM_MACS(N), .IN_WIDTH(IW), .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(2), .RELU_EN(0))
    u2 (.clk(clk), .rst_in(rst_in), .bus(if2));

  typedef struct {
    int d0;
    int d1;
    int d2;
    int idx;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_en    = 1'b0;
  bit    after_rst = 1'b1;
  bit    cap_taken = 1'b0;

  function automatic int rq(input longint v, input int sc, input bit relu);
    longint s;
    s = v >>> sc;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string p, input logic ov, input logic cr, input logic bs,
                         input logic ol, input logic signed [OW-1:0] od, input logic [1:0] oi,
                         input bit ev, input bit ecr, input int ed, input int ei, input bit el,
                         input bit full);
    chk({p, "_out_valid"}, longint'(ov), longint'(ev));
    chk({p, "_busy"}, longint'(bs), longint'(ev));
    chk({p, "_capture_ready"}, longint'(cr), longint'(ecr));
    chk({p, "_out_last"}, longint'(ol), longint'(el));
    if (full) begin
      chk({p, "_out_data"}, longint'(od), longint'(ed));
      chk({p, "_out_index"}, longint'(oi), longint'(ei));
    end
  endtask

  // Monitor / scoreboard: compare, then advance the model on the upcoming edge's handshakes
  always @(negedge clk) begin
    beat_t b;
    bit    ev;
    bit    ecr;
    int    n;
    n   = exp_q.size();
    ev  = (n > 0);
    ecr = (n == 0) || (n == 1 && out_rdy);
    b   = '{default: 0};
    if (ev) b = exp_q[0];
    if (mon_en) begin
      chk_dut("u0", if0.out_valid, if0.capture_ready, if0.busy, if0.out_last, if0.out_data,
              if0.out_index, ev, ecr, b.d0, b.idx, b.last, ev || after_rst);
      chk_dut("u1", if1.out_valid, if1.capture_ready, if1.busy, if1.out_last, if1.out_data,
              if1.out_index, ev, ecr, b.d1, b.idx, b.last, ev || after_rst);
      chk_dut("u2", if2.out_valid, if2.capture_ready, if2.busy, if2.out_last, if2.out_data,
              if2.out_index, ev, ecr, b.d2, b.idx, b.last, ev || after_rst);
    end
    if (rst_in) begin
      exp_q.delete();
      after_rst = 1'b1;
      cap_taken = 1'b0;
    end else begin
      if (ev && out_rdy) void'(exp_q.pop_front());
      if (cap_valid && ecr) begin
        for (int i = 0; i < N; i++) begin
          beat_t nb;
          longint v;
          v       = longint'($signed(mac_vals[i*IW +: IW]));
          nb.d0   = rq(v, 0, 1'b0);
          nb.d1   = rq(v, 2, 1'b1);
          nb.d2   = rq(v, 2, 1'b0);
          nb.idx  = i;
          nb.last = (i == N - 1);
          exp_q.push_back(nb);
        end
        after_rst = 1'b0;
        cap_taken = 1'b1;
      end else begin
        cap_taken = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int rv();
    case ($urandom_range(0, 2))
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom_range(0, 4000)) - 2000;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic scramble();
    for (int i = 0; i < N; i++) mac_vals[i*IW +: IW] = rv();
  endtask

  task automatic capture(input int a, input int b, input int c, input int d);
    mac_vals  = {d, c, b, a};
    cap_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (cap_taken) break;
    end
    chk("capture_accept", longint'(cap_taken), 64'sd1);
    cap_valid = 1'b0;
    scramble();
  endtask

  initial begin
    rst_in    = 1'b1;
    cap_valid = 1'b0;
    out_rdy   = 1'b0;
    mac_vals  = '0;
    step();
    mon_en = 1'b1;
    step();
    rst_in = 1'b0;
    step();
    step();

    // basic drain, then a second snapshot held until the last-beat handshake
    out_rdy = 1'b1;
    capture(3, -5, 127, -128);
    capture(9, 8, 7, 6);
    step();
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    capture(1, 2, 3, 4);
    repeat (5) step();

    // saturation/shift/ReLU with backpressure parked at index 1
    capture(1000, -1000, 509, 7);
    step();
    out_rdy   = 1'b0;
    mac_vals  = {32'sd5, 32'sd5, 32'sd5, 32'sd5};
    cap_valid = 1'b1;
    repeat (5) step();
    out_rdy = 1'b1;
    capture(5, 5, 5, 5);
    repeat (6) step();

    for (int c = 0; c < 400; c++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      rst_in  = ($urandom_range(0, 149) == 0);
      if (cap_valid && cap_taken) begin
        cap_valid = 1'b0;
        scramble();
      end else if (!cap_valid && $urandom_range(0, 3) == 0) begin
        scramble();
        cap_valid = 1'b1;
      end else if (!cap_valid) begin
        scramble();
      end
      step();
    end

    rst_in    = 1'b0;
    cap_valid = 1'b0;
    out_rdy   = 1'b1;
    repeat (8) step();
    chk("queue_empty", longint'(exp_q.size()), 64'sd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
